ch0re_decode_ctrl: RTL and testbench



---
 rtl/ch0re_decode_ctrl_pkg.sv | 34 +++
 rtl/ch0re_decode_ctrl_if.sv | 51 +++++
 rtl/ch0re_scoreboard.sv | 57 +++++
 rtl/ch0re_decode_ctrl.sv | 100 ++++++++++
 tb/tb_ch0re_decode_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ch0re_decode_ctrl_pkg.sv
// Shared types for the ch0re decode-stage controller: instruction formats,
// the NOP encoding, FSM states, and register-use helpers.
package ch0re_decode_ctrl_pkg;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } ch0re_iformat_t;

    localparam logic [31:0] CH0RE_NOP = 32'h0000_0013;

    typedef enum logic {
        ST_RUN,
        ST_TRAP
    } dec_state_t;

    function automatic logic reads_rs1(ch0re_iformat_t f);
        return f inside {FMT_R, FMT_I, FMT_S, FMT_B};
    endfunction

    function automatic logic reads_rs2(ch0re_iformat_t f);
        return f inside {FMT_R, FMT_S, FMT_B};
    endfunction

    // Store/branch formats never produce a register write, whatever wen says.
    function automatic logic writes_rd(ch0re_iformat_t f);
        return f inside {FMT_R, FMT_I, FMT_U, FMT_J};
    endfunction

endpackage

// File: rtl/ch0re_decode_ctrl_if.sv
// Fetch, decoder, execute and writeback signals of the decode controller,
// plus debug visibility of the FSM state and decode-register valid bit.
interface ch0re_decode_ctrl_if #(
    parameter int XLEN        = 64,
    parameter int STALL_CNT_W = 32
);
    import ch0re_decode_ctrl_pkg::*;

    // Valid/ready: a beat transfers on a rising clock edge where both valid
    // and ready are high; valid never depends on ready on the same interface.
    logic                   i_if_valid;
    logic [31:0]            i_if_instr;
    logic [XLEN-1:0]        i_if_pc;
    logic                   o_if_ready;
    logic [31:0]            o_dec_instr;
    logic                   i_dec_illegal;
    logic                   i_dec_wen;
    ch0re_iformat_t         i_dec_format;
    logic [4:0]             i_dec_raddr1;
    logic [4:0]             i_dec_raddr2;
    logic [4:0]             i_dec_waddr;
    logic                   o_ex_valid;
    logic                   i_ex_ready;
    logic [XLEN-1:0]        o_ex_pc;
    logic                   i_wb_valid;
    logic [4:0]             i_wb_waddr;
    logic                   i_flush;
    logic                   o_illegal_trap;
    logic [STALL_CNT_W-1:0] o_stall_cnt;
    dec_state_t             o_dbg_state;
    logic                   o_dbg_d_valid;

    modport slave (
        input  i_if_valid, i_if_instr, i_if_pc,
        input  i_dec_illegal, i_dec_wen, i_dec_format,
        input  i_dec_raddr1, i_dec_raddr2, i_dec_waddr,
        input  i_ex_ready, i_wb_valid, i_wb_waddr, i_flush,
        output o_if_ready, o_dec_instr, o_ex_valid, o_ex_pc,
        output o_illegal_trap, o_stall_cnt, o_dbg_state, o_dbg_d_valid
    );

    modport master (
        output i_if_valid, i_if_instr, i_if_pc,
        output i_dec_illegal, i_dec_wen, i_dec_format,
        output i_dec_raddr1, i_dec_raddr2, i_dec_waddr,
        output i_ex_ready, i_wb_valid, i_wb_waddr, i_flush,
        input  o_if_ready, o_dec_instr, o_ex_valid, o_ex_pc,
        input  o_illegal_trap, o_stall_cnt, o_dbg_state, o_dbg_d_valid
    );

endinterface

// File: rtl/ch0re_scoreboard.sv
// Per-register outstanding-write counters with busy/full queries for the
// two source registers and the destination of the instruction in decode.
module ch0re_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_inc_en,
    input  logic [4:0] i_inc_addr,
    input  logic       i_dec_en,
    input  logic [4:0] i_dec_addr,
    input  logic [4:0] i_rs1_addr,
    input  logic [4:0] i_rs2_addr,
    input  logic [4:0] i_rd_addr,
    output logic       o_rs1_busy,
    output logic       o_rs2_busy,
    output logic       o_rd_full
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q [32];
    logic [CNT_W-1:0] cnt_d [32];

    // x0 is never tracked, so its counter stays at zero.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 1; i < 32; i++) begin
            if (i_inc_en && i_inc_addr == 5'(i) && !(i_dec_en && i_dec_addr == 5'(i))
                && cnt_q[i] != CNT_MAX) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (i_dec_en && i_dec_addr == 5'(i) && !(i_inc_en && i_inc_addr == 5'(i))
                && cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            assert (!(i_dec_en && i_dec_addr != 5'd0 && cnt_q[i_dec_addr] == '0
                      && !(i_inc_en && i_inc_addr == i_dec_addr)));
        end
    end

    assign o_rs1_busy = cnt_q[i_rs1_addr] != '0;
    assign o_rs2_busy = cnt_q[i_rs2_addr] != '0;
    assign o_rd_full  = cnt_q[i_rd_addr] == CNT_MAX;

endmodule

// File: rtl/ch0re_decode_ctrl.sv
// Decode-stage controller: one-entry decode register feeding the decoder,
// RAW/saturation hazard stall, issue handshake, flush and illegal-trap FSM.
module ch0re_decode_ctrl
    import ch0re_decode_ctrl_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int SB_CNT_W    = 2,
    parameter int STALL_CNT_W = 32
) (
    input  logic                i_clk,
    input  logic                i_rst,
    ch0re_decode_ctrl_if.slave  bus
);
    dec_state_t             state_q, state_d;
    logic                   d_valid_q, d_valid_d;
    logic [31:0]            d_instr_q, d_instr_d;
    logic [XLEN-1:0]        d_pc_q, d_pc_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic rs1_busy, rs2_busy, rd_full;
    logic rd_wr, hazard, ex_valid, fire, if_ready, accept, trap, stall_cycle;

    ch0re_scoreboard #(.CNT_W(SB_CNT_W)) u_sb (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_inc_en   (fire && rd_wr),
        .i_inc_addr (bus.i_dec_waddr),
        .i_dec_en   (bus.i_wb_valid && bus.i_wb_waddr != 5'd0),
        .i_dec_addr (bus.i_wb_waddr),
        .i_rs1_addr (bus.i_dec_raddr1),
        .i_rs2_addr (bus.i_dec_raddr2),
        .i_rd_addr  (bus.i_dec_waddr),
        .o_rs1_busy (rs1_busy),
        .o_rs2_busy (rs2_busy),
        .o_rd_full  (rd_full)
    );

    // Decoder is combinational on o_dec_instr, so its outputs describe d_instr_q now.
    always_comb begin
        rd_wr  = bus.i_dec_wen && writes_rd(bus.i_dec_format) && bus.i_dec_waddr != 5'd0;
        hazard = (reads_rs1(bus.i_dec_format) && bus.i_dec_raddr1 != 5'd0 && rs1_busy)
              || (reads_rs2(bus.i_dec_format) && bus.i_dec_raddr2 != 5'd0 && rs2_busy)
              || (rd_wr && rd_full);
        ex_valid    = d_valid_q && state_q == ST_RUN && !hazard && !bus.i_dec_illegal && !bus.i_flush;
        fire        = ex_valid && bus.i_ex_ready;
        if_ready    = state_q == ST_RUN && !bus.i_flush && (!d_valid_q || fire);
        accept      = bus.i_if_valid && if_ready;
        trap        = state_q == ST_RUN && d_valid_q && bus.i_dec_illegal && !bus.i_flush;
        stall_cycle = d_valid_q && state_q == ST_RUN && hazard && !bus.i_flush;
    end

    always_comb begin
        state_d     = state_q;
        d_valid_d   = d_valid_q;
        d_instr_d   = d_instr_q;
        d_pc_d      = d_pc_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            ST_RUN:  if (trap) state_d = ST_TRAP;
            ST_TRAP: if (bus.i_flush) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
        if (bus.i_flush) begin
            d_valid_d = 1'b0;
        end else if (accept) begin
            d_valid_d = 1'b1;
            d_instr_d = bus.i_if_instr;
            d_pc_d    = bus.i_if_pc;
        end else if (fire) begin
            d_valid_d = 1'b0;
        end
        if (stall_cycle && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_RUN;
            d_valid_q   <= 1'b0;
            d_instr_q   <= CH0RE_NOP;
            d_pc_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            d_valid_q   <= d_valid_d;
            d_instr_q   <= d_instr_d;
            d_pc_q      <= d_pc_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.o_dec_instr    = d_valid_q ? d_instr_q : CH0RE_NOP;
    assign bus.o_if_ready     = if_ready;
    assign bus.o_ex_valid     = ex_valid;
    assign bus.o_ex_pc        = d_pc_q;
    assign bus.o_illegal_trap = trap;
    assign bus.o_stall_cnt    = stall_cnt_q;
    assign bus.o_dbg_state    = state_q;
    assign bus.o_dbg_d_valid  = d_valid_q;

endmodule

// File: tb/tb_ch0re_decode_ctrl.sv
// Directed bench for ch0re_decode_ctrl with a small behavioural decoder and
// an issue-order scoreboard keyed on PC.
module tb_ch0re_decode_ctrl;
  import ch0re_decode_ctrl_pkg::*;

  logic i_clk = 1'b0;
  logic i_rst;
  logic force_wen;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   exp_stall = 0;
  logic [63:0] exp_q[$];
  ch0re_iformat_t fmt;

  ch0re_decode_ctrl_if #(.XLEN(64), .STALL_CNT_W(32)) bus();

  ch0re_decode_ctrl #(.XLEN(64), .SB_CNT_W(2), .STALL_CNT_W(32)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  // clock / reset block
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // behavioural decoder on o_dec_instr
  always_comb begin
    fmt = FMT_I;
    bus.i_dec_illegal = 1'b0;
    case (bus.o_dec_instr[6:0])
      7'h13, 7'h03, 7'h67: fmt = FMT_I;
      7'h33:               fmt = FMT_R;
      7'h23:               fmt = FMT_S;
      7'h63:               fmt = FMT_B;
      7'h37, 7'h17:        fmt = FMT_U;
      7'h6F:               fmt = FMT_J;
      default:             bus.i_dec_illegal = 1'b1;
    endcase
    bus.i_dec_format = fmt;
    bus.i_dec_raddr1 = bus.o_dec_instr[19:15];
    bus.i_dec_raddr2 = bus.o_dec_instr[24:20];
    bus.i_dec_waddr  = bus.o_dec_instr[11:7];
    bus.i_dec_wen    = !bus.i_dec_illegal && (force_wen || (fmt != FMT_S && fmt != FMT_B));
  end

  function automatic logic [31:0] addi(int rd, int rs1, int imm);
    return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'h13};
  endfunction

  function automatic logic [31:0] add(int rd, int rs1, int rs2);
    return {7'h00, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] sw(int rs2, int rs1, int imm);
    return {7'(imm >> 5), 5'(rs2), 5'(rs1), 3'b010, 5'(imm), 7'h23};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic fetch(input logic [31:0] instr, input logic [63:0] pc, input bit push);
    int n;
    n = 0;
    bus.i_if_valid = 1'b1;
    bus.i_if_instr = instr;
    bus.i_if_pc    = pc;
    if (push) exp_q.push_back(pc);
    #1;
    while (!bus.o_if_ready && n < 40) begin
      step();
      #1;
      n++;
    end
    chk("fetch_accept", 64'(n < 40), 64'd1);
    step();
    bus.i_if_valid = 1'b0;
  endtask

  task automatic wb(input int addr);
    bus.i_wb_valid = 1'b1;
    bus.i_wb_waddr = 5'(addr);
    step();
    bus.i_wb_valid = 1'b0;
  endtask

  task automatic expect_stall(input string tag);
    chk({tag, "_stall_cnt"}, 64'(bus.o_stall_cnt), 64'(exp_stall));
    chk({tag, "_held"}, 64'(bus.o_ex_valid), 64'd0);
    exp_stall++;
  endtask

  // scoreboard: every issue must match the next expected PC
  always @(negedge i_clk) begin
    if (!i_rst && bus.o_ex_valid && bus.i_ex_ready) begin
      chk("issue_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) chk("issue_pc", bus.o_ex_pc, exp_q.pop_front());
    end
  end

  initial begin
    i_rst = 1'b1;
    force_wen = 1'b0;
    bus.i_if_valid = 1'b0;
    bus.i_if_instr = '0;
    bus.i_if_pc    = '0;
    bus.i_ex_ready = 1'b1;
    bus.i_wb_valid = 1'b0;
    bus.i_wb_waddr = '0;
    bus.i_flush    = 1'b0;
    repeat (2) @(posedge i_clk);
    #2;
    chk("rst_if_ready", 64'(bus.o_if_ready), 64'd1);
    chk("rst_ex_valid", 64'(bus.o_ex_valid), 64'd0);
    chk("rst_trap", 64'(bus.o_illegal_trap), 64'd0);
    chk("rst_stall", 64'(bus.o_stall_cnt), 64'd0);
    chk("rst_state", 64'(bus.o_dbg_state), 64'(ST_RUN));
    chk("rst_dec_nop", 64'(bus.o_dec_instr), 64'(CH0RE_NOP));
    i_rst = 1'b0;

    // back-to-back issue
    fetch(addi(1, 0, 1), 64'h100, 1'b1);
    settle();
    chk("b2b_first_valid", 64'(bus.o_ex_valid), 64'd1);
    fetch(addi(2, 0, 2), 64'h104, 1'b1);
    settle();
    chk("b2b_second_valid", 64'(bus.o_ex_valid), 64'd1);
    chk("b2b_stall", 64'(bus.o_stall_cnt), 64'd0);
    step();
    settle();
    chk("b2b_drained", 64'(bus.o_ex_valid), 64'd0);
    chk("b2b_ready", 64'(bus.o_if_ready), 64'd1);
    wb(1);
    wb(2);

    // execute backpressure
    bus.i_ex_ready = 1'b0;
    fetch(addi(4, 0, 4), 64'h120, 1'b1);
    settle();
    chk("bp_valid", 64'(bus.o_ex_valid), 64'd1);
    chk("bp_if_ready", 64'(bus.o_if_ready), 64'd0);
    step();
    bus.i_ex_ready = 1'b1;
    settle();
    chk("bp_if_ready_on_fire", 64'(bus.o_if_ready), 64'd1);
    step();
    settle();
    chk("bp_drained", 64'(bus.o_ex_valid), 64'd0);
    chk("bp_no_stall", 64'(bus.o_stall_cnt), 64'd0);
    wb(4);

    // RAW stall released by writeback
    fetch(addi(1, 0, 1), 64'h200, 1'b1);
    fetch(add(3, 1, 1), 64'h204, 1'b1);
    settle();
    expect_stall("raw0");
    step();
    settle();
    expect_stall("raw1");
    step();
    bus.i_wb_valid = 1'b1;
    bus.i_wb_waddr = 5'd1;
    settle();
    expect_stall("raw2");
    step();
    bus.i_wb_valid = 1'b0;
    settle();
    chk("raw_issue", 64'(bus.o_ex_valid), 64'd1);
    chk("raw_stall_cnt", 64'(bus.o_stall_cnt), 64'd3);
    step();
    settle();
    chk("raw_drained", 64'(bus.o_ex_valid), 64'd0);
    wb(3);

    // x0 destination and store rules
    fetch(addi(0, 0, 5), 64'h300, 1'b1);
    settle();
    chk("x0_issue", 64'(bus.o_ex_valid), 64'd1);
    step();
    fetch(addi(2, 0, 2), 64'h310, 1'b1);
    fetch(sw(2, 1, 0), 64'h314, 1'b1);
    settle();
    expect_stall("sw0");
    step();
    bus.i_wb_valid = 1'b1;
    bus.i_wb_waddr = 5'd2;
    settle();
    expect_stall("sw1");
    step();
    bus.i_wb_valid = 1'b0;
    settle();
    chk("sw_issue", 64'(bus.o_ex_valid), 64'd1);
    step();
    force_wen = 1'b1;
    fetch(sw(2, 1, 2), 64'h320, 1'b1);
    settle();
    chk("sw_wen_issue", 64'(bus.o_ex_valid), 64'd1);
    fetch(add(8, 2, 2), 64'h324, 1'b1);
    force_wen = 1'b0;
    settle();
    chk("sw_wen_no_count", 64'(bus.o_ex_valid), 64'd1);
    step();
    wb(8);

    // saturation of cnt[5]
    fetch(addi(5, 0, 1), 64'h400, 1'b1);
    fetch(addi(5, 0, 2), 64'h404, 1'b1);
    fetch(addi(5, 0, 3), 64'h408, 1'b1);
    fetch(addi(5, 0, 4), 64'h40C, 1'b1);
    settle();
    expect_stall("sat0");
    step();
    bus.i_wb_valid = 1'b1;
    bus.i_wb_waddr = 5'd5;
    settle();
    expect_stall("sat1");
    step();
    bus.i_wb_valid = 1'b0;
    settle();
    chk("sat_issue", 64'(bus.o_ex_valid), 64'd1);
    step();
    wb(5);
    wb(5);
    wb(5);

    // flush of a stalled instruction, with a fetch beat competing
    fetch(addi(1, 0, 1), 64'h500, 1'b1);
    fetch(add(3, 1, 1), 64'h504, 1'b0);
    settle();
    expect_stall("fl0");
    step();
    bus.i_flush    = 1'b1;
    bus.i_if_valid = 1'b1;
    bus.i_if_instr = addi(9, 0, 9);
    bus.i_if_pc    = 64'h5F0;
    settle();
    chk("flush_if_ready", 64'(bus.o_if_ready), 64'd0);
    chk("flush_ex_valid", 64'(bus.o_ex_valid), 64'd0);
    step();
    bus.i_flush    = 1'b0;
    bus.i_if_valid = 1'b0;
    settle();
    chk("flush_d_clear", 64'(bus.o_dbg_d_valid), 64'd0);
    chk("flush_no_issue", 64'(bus.o_ex_valid), 64'd0);
    chk("flush_stall_cnt", 64'(bus.o_stall_cnt), 64'(exp_stall));
    fetch(add(3, 1, 1), 64'h508, 1'b1);
    settle();
    expect_stall("fl1");
    step();
    bus.i_wb_valid = 1'b1;
    bus.i_wb_waddr = 5'd1;
    settle();
    expect_stall("fl2");
    step();
    bus.i_wb_valid = 1'b0;
    settle();
    chk("flush_reissue", 64'(bus.o_ex_valid), 64'd1);
    step();
    wb(3);

    // illegal instruction trap
    fetch(32'hFFFF_FFFF, 64'h600, 1'b0);
    bus.i_if_valid = 1'b1;
    bus.i_if_instr = addi(9, 0, 9);
    bus.i_if_pc    = 64'h610;
    settle();
    chk("ill_pulse", 64'(bus.o_illegal_trap), 64'd1);
    chk("ill_ex_valid", 64'(bus.o_ex_valid), 64'd0);
    chk("ill_if_ready", 64'(bus.o_if_ready), 64'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      settle();
      chk("trap_no_repulse", 64'(bus.o_illegal_trap), 64'd0);
      chk("trap_if_ready", 64'(bus.o_if_ready), 64'd0);
      chk("trap_ex_valid", 64'(bus.o_ex_valid), 64'd0);
      chk("trap_state", 64'(bus.o_dbg_state), 64'(ST_TRAP));
      chk("trap_d_held", 64'(bus.o_dbg_d_valid), 64'd1);
    end
    step();
    bus.i_flush = 1'b1;
    settle();
    chk("trap_flush_if_ready", 64'(bus.o_if_ready), 64'd0);
    step();
    bus.i_flush = 1'b0;
    exp_q.push_back(64'h610);
    settle();
    chk("trap_exit_state", 64'(bus.o_dbg_state), 64'(ST_RUN));
    chk("trap_exit_d_valid", 64'(bus.o_dbg_d_valid), 64'd0);
    chk("trap_exit_if_ready", 64'(bus.o_if_ready), 64'd1);
    step();
    bus.i_if_valid = 1'b0;
    settle();
    chk("post_trap_issue", 64'(bus.o_ex_valid), 64'd1);
    step();
    wb(9);

    // reset while trapped, with a register write outstanding
    fetch(addi(10, 0, 1), 64'h700, 1'b1);
    fetch(32'hFFFF_FFFF, 64'h704, 1'b0);
    step();
    settle();
    chk("pre_rst_state", 64'(bus.o_dbg_state), 64'(ST_TRAP));
    i_rst = 1'b1;
    bus.i_ex_ready = 1'b0;
    step();
    i_rst = 1'b0;
    bus.i_ex_ready = 1'b1;
    exp_stall = 0;
    settle();
    chk("mid_rst_state", 64'(bus.o_dbg_state), 64'(ST_RUN));
    chk("mid_rst_trap", 64'(bus.o_illegal_trap), 64'd0);
    chk("mid_rst_stall", 64'(bus.o_stall_cnt), 64'd0);
    chk("mid_rst_ex_valid", 64'(bus.o_ex_valid), 64'd0);
    chk("mid_rst_if_ready", 64'(bus.o_if_ready), 64'd1);
    chk("mid_rst_d_valid", 64'(bus.o_dbg_d_valid), 64'd0);
    fetch(add(11, 10, 10), 64'h708, 1'b1);
    settle();
    chk("mid_rst_sb_clear", 64'(bus.o_ex_valid), 64'd1);
    repeat (3) step();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
